bird_motion_controller: RTL



---
 rtl/flappy_pkg.sv | 17 +
 rtl/bird_motion_controller_if.sv | 31 +++
 rtl/bird_motion_controller_physics_step.sv | 57 +++++
 rtl/bird_motion_controller.sv | 108 ++++++++++
 4 files changed

// File: rtl/flappy_pkg.sv
// Shared game definitions: bird FSM encoding and default physics constants
// used by the motion, renderer and collision blocks.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLYING  = 2'd1,
    CRASHED = 2'd2
  } bird_state_t;

  localparam int DEF_START_Y  = 60;
  localparam int DEF_GROUND_Y = 110;
  localparam int DEF_GRAVITY  = 1;
  localparam int DEF_FLAP_VEL = 6;
  localparam int DEF_MAX_FALL = 7;

endpackage

// File: rtl/bird_motion_controller_if.sv
// Control strobes in, bird kinematics out, between the game logic and the
// bird motion controller.
interface bird_motion_controller_if
  import flappy_pkg::*;
#(
  parameter int Y_WIDTH   = 7,
  parameter int VEL_WIDTH = 5
);
  // flapPulse, frameTick and restart are single-cycle strobes with no
  // back-pressure; pipeHit is a level. Outputs are registered in the slave.
  logic                        flapPulse;
  logic                        frameTick;
  logic                        pipeHit;
  logic                        restart;
  logic [Y_WIDTH-1:0]          birdY;
  logic signed [VEL_WIDTH-1:0] birdVel;
  logic                        flying;
  logic                        crashed;
  bird_state_t                 state;

  modport master (
    output flapPulse, frameTick, pipeHit, restart,
    input  birdY, birdVel, flying, crashed, state
  );

  modport slave (
    input  flapPulse, frameTick, pipeHit, restart,
    output birdY, birdVel, flying, crashed, state
  );

endinterface

// File: rtl/bird_motion_controller_physics_step.sv
// One physics step: flap impulse or saturating gravity, then ceiling clamp
// and ground detection on the resulting position.
module bird_physics_step #(
  parameter int Y_WIDTH   = 7,
  parameter int VEL_WIDTH = 5,
  parameter int GROUND_Y  = 110,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = 6,
  parameter int MAX_FALL  = 7
) (
  input  logic [Y_WIDTH-1:0]          y,
  input  logic signed [VEL_WIDTH-1:0] vel,
  input  logic                        flap,
  output logic [Y_WIDTH-1:0]          next_y,
  output logic signed [VEL_WIDTH-1:0] next_vel,
  output logic                        hit_ground
);

  localparam int FW = VEL_WIDTH + 2;
  localparam int SW = Y_WIDTH + 2;

  localparam logic signed [FW-1:0]        GRAV_F   = FW'(GRAVITY);
  localparam logic signed [FW-1:0]        MAXF_F   = FW'(MAX_FALL);
  localparam logic signed [VEL_WIDTH-1:0] FLAP_V   = VEL_WIDTH'(-FLAP_VEL);
  localparam logic signed [SW-1:0]        GROUND_S = SW'(GROUND_Y);
  localparam logic [Y_WIDTH-1:0]          GROUND_W = Y_WIDTH'(GROUND_Y);

  logic signed [FW-1:0]        fall;
  logic signed [VEL_WIDTH-1:0] vel_new;
  logic signed [SW-1:0]        y_new;

  always_comb begin
    fall = FW'(vel) + GRAV_F;
    if (flap)
      vel_new = FLAP_V;
    else if (fall > MAXF_F)
      vel_new = VEL_WIDTH'(MAXF_F);
    else
      vel_new = VEL_WIDTH'(fall);

    // Position is evaluated two bits wider so both overshoots are visible.
    y_new = $signed({2'b00, y}) + SW'(vel_new);

    next_y     = y_new[Y_WIDTH-1:0];
    next_vel   = vel_new;
    hit_ground = 1'b0;
    if (y_new[SW-1]) begin
      next_y   = '0;
      next_vel = '0;
    end else if (y_new >= GROUND_S) begin
      next_y     = GROUND_W;
      next_vel   = '0;
      hit_ground = 1'b1;
    end
  end

endmodule

// File: rtl/bird_motion_controller.sv
// Bird vertical motion FSM: IDLE until the first flap, FLYING with per-frame
// physics, CRASHED on ground or pipe contact until restart.
module bird_motion_controller
  import flappy_pkg::*;
#(
  parameter int Y_WIDTH   = 7,
  parameter int VEL_WIDTH = 5,
  parameter int START_Y   = DEF_START_Y,
  parameter int GROUND_Y  = DEF_GROUND_Y,
  parameter int GRAVITY   = DEF_GRAVITY,
  parameter int FLAP_VEL  = DEF_FLAP_VEL,
  parameter int MAX_FALL  = DEF_MAX_FALL
) (
  input logic                     clk,
  input logic                     resetLow,
  bird_motion_controller_if.slave bus
);

  localparam logic [Y_WIDTH-1:0] START_W = Y_WIDTH'(START_Y);

  bird_state_t                 state_q, state_d;
  logic [Y_WIDTH-1:0]          y_q, y_d;
  logic signed [VEL_WIDTH-1:0] vel_q, vel_d;
  logic                        pending_q, pending_d;

  logic [Y_WIDTH-1:0]          step_y;
  logic signed [VEL_WIDTH-1:0] step_vel;
  logic                        step_hit;

  bird_physics_step #(
    .Y_WIDTH  (Y_WIDTH),
    .VEL_WIDTH(VEL_WIDTH),
    .GROUND_Y (GROUND_Y),
    .GRAVITY  (GRAVITY),
    .FLAP_VEL (FLAP_VEL),
    .MAX_FALL (MAX_FALL)
  ) u_step (
    .y         (y_q),
    .vel       (vel_q),
    .flap      (pending_q | bus.flapPulse),
    .next_y    (step_y),
    .next_vel  (step_vel),
    .hit_ground(step_hit)
  );

  always_ff @(posedge clk or negedge resetLow) begin
    if (!resetLow) begin
      state_q   <= IDLE;
      y_q       <= START_W;
      vel_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      vel_q     <= vel_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    vel_d     = vel_q;
    pending_d = pending_q;
    if (bus.restart) begin
      state_d   = IDLE;
      y_d       = START_W;
      vel_d     = '0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.flapPulse) begin
            state_d   = FLYING;
            pending_d = 1'b1;
          end
        end
        FLYING: begin
          // A pipe contact freezes the bird even when a tick coincides.
          if (bus.pipeHit) begin
            state_d = CRASHED;
          end else if (bus.frameTick) begin
            y_d       = step_y;
            vel_d     = step_vel;
            pending_d = 1'b0;
            if (step_hit) state_d = CRASHED;
          end else if (bus.flapPulse) begin
            pending_d = 1'b1;
          end
        end
        CRASHED: state_d = CRASHED;
        default: begin
          state_d   = IDLE;
          y_d       = START_W;
          vel_d     = '0;
          pending_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.birdY   = y_q;
  assign bus.birdVel = vel_q;
  assign bus.flying  = (state_q == FLYING);
  assign bus.crashed = (state_q == CRASHED);
  assign bus.state   = state_q;

endmodule
